// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Register-file writeback arbiter. ALU results take priority
//               over a 2-deep load FIFO. A pending-load scoreboard drives the
//               stall output and the sticky WAW error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int A     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [A-1:0]     alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_valid,
    input  logic [A-1:0]     ld_rd,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    input  logic             iss_load,
    input  logic [A-1:0]     iss_rd,
    input  logic [A-1:0]     chk_rs1,
    input  logic [A-1:0]     chk_rs2,
    output logic             stall,
    output logic [A-1:0]     wr_addr0,
    output logic [WIDTH-1:0] wr_din0,
    output logic             we0,
    output logic [1:0]       fifo_cnt,
    output logic             waw_err
);

    localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

    logic [A-1:0]     r_fifo_rd   [2];
    logic [WIDTH-1:0] r_fifo_data [2];
    logic [1:0]       r_cnt;
    logic [DEPTH-1:0] r_pending;
    logic             r_waw;
    logic             r_we;
    logic [A-1:0]     r_addr;
    logic [WIDTH-1:0] r_din;

    logic             w_push;
    logic             w_pop;
    logic             w_sel_valid;
    logic [A-1:0]     w_sel_rd;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_wr;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_pending_nxt;

    assign ld_ready = (r_cnt < c_FIFO_DEPTH);
    assign w_push   = ld_valid & ld_ready;
    // The FIFO head only drains on cycles the ALU leaves the write port idle.
    assign w_pop    = ~alu_valid & (r_cnt != 2'd0);

    assign w_sel_valid = alu_valid | (r_cnt != 2'd0);
    assign w_sel_rd    = alu_valid ? alu_rd   : r_fifo_rd[0];
    assign w_sel_data  = alu_valid ? alu_data : r_fifo_data[0];
    assign w_wr        = w_sel_valid & (w_sel_rd != '0);

    // In-order FIFO with the head always in slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_fifo_rd[r_cnt[0]]   <= ld_rd;
                    r_fifo_data[r_cnt[0]] <= ld_data;
                    r_cnt                 <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_fifo_rd[0]   <= r_fifo_rd[1];
                    r_fifo_data[0] <= r_fifo_data[1];
                    r_cnt          <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_fifo_rd[0]   <= ld_rd;
                        r_fifo_data[0] <= ld_data;
                    end else begin
                        r_fifo_rd[0]   <= r_fifo_rd[1];
                        r_fifo_data[0] <= r_fifo_data[1];
                        r_fifo_rd[1]   <= ld_rd;
                        r_fifo_data[1] <= ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear is applied before set so a same-cycle issue re-arms the entry.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_pop)
            w_clr[r_fifo_rd[0]] = 1'b1;
        if (iss_load)
            w_set[iss_rd] = 1'b1;
        w_pending_nxt    = (r_pending & ~w_clr) | w_set;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_waw     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (alu_valid && (alu_rd != '0) && r_pending[alu_rd])
                r_waw <= 1'b1;
        end
    end

    // Address/data only move on a real write so they never show stale garbage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_addr <= w_sel_rd;
                r_din  <= w_sel_data;
            end
        end
    end

    assign stall    = r_pending[chk_rs1] | r_pending[chk_rs2];
    assign we0      = r_we;
    assign wr_addr0 = r_addr;
    assign wr_din0  = r_din;
    assign fifo_cnt = r_cnt;
    assign waw_err  = r_waw;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Directed and randomized bench for regfile_writeback against a
//               queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int A     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid;
    logic [A-1:0]     alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             ld_valid;
    logic [A-1:0]     ld_rd;
    logic [WIDTH-1:0] ld_data;
    logic             ld_ready;
    logic             iss_load;
    logic [A-1:0]     iss_rd;
    logic [A-1:0]     chk_rs1;
    logic [A-1:0]     chk_rs2;
    logic             stall;
    logic [A-1:0]     wr_addr0;
    logic [WIDTH-1:0] wr_din0;
    logic             we0;
    logic [1:0]       fifo_cnt;
    logic             waw_err;

    regfile_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .iss_load  (iss_load),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .stall     (stall),
        .wr_addr0  (wr_addr0),
        .wr_din0   (wr_din0),
        .we0       (we0),
        .fifo_cnt  (fifo_cnt),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rd;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    bit          pend[DEPTH];
    logic        exp_we;
    logic [A-1:0] exp_addr;
    logic [31:0] exp_din;
    logic        exp_waw;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) pend[i] = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
        exp_waw  = 1'b0;
    endtask

    // Apply one cycle of inputs, check combinational outputs, advance the
    // model across the edge and check the registered outputs.
    task automatic step(input bit av, input int ard, input logic [31:0] adata,
                        input bit lv, input int lrd, input logic [31:0] ldata,
                        input bit il, input int ird, input int c1, input int c2);
        bit          have;
        bit          acc;
        int          crd;
        logic [31:0] cdat;
        entry_t      e;
        alu_valid = av;  alu_rd = A'(ard);  alu_data = adata;
        ld_valid  = lv;  ld_rd  = A'(lrd);  ld_data  = ldata;
        iss_load  = il;  iss_rd = A'(ird);
        chk_rs1   = A'(c1); chk_rs2 = A'(c2);
        #1;
        chk("ld_ready", 64'(ld_ready), 64'(q.size() < 2));
        chk("stall", 64'(stall), 64'(pend[c1] | pend[c2]));
        chk("fifo_cnt_pre", 64'(fifo_cnt), 64'(q.size()));
        acc  = lv && (q.size() < 2);
        have = 1'b0;
        crd  = 0;
        cdat = '0;
        if (av) begin
            have = 1'b1; crd = ard; cdat = adata;
            if (ard != 0 && pend[ard]) exp_waw = 1'b1;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            have = 1'b1; crd = e.rd; cdat = e.data;
            pend[e.rd] = 1'b0;
        end
        if (acc) begin
            e.rd = lrd; e.data = ldata;
            q.push_back(e);
        end
        if (il && ird != 0) pend[ird] = 1'b1;
        exp_we = have && (crd != 0);
        if (exp_we) begin
            exp_addr = A'(crd);
            exp_din  = cdat;
        end
        @(posedge clk);
        #1;
        chk("we0", 64'(we0), 64'(exp_we));
        chk("wr_addr0", 64'(wr_addr0), 64'(exp_addr));
        chk("wr_din0", 64'(wr_din0), 64'(exp_din));
        chk("waw_err", 64'(waw_err), 64'(exp_waw));
        chk("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
    endtask

    task automatic idle(input int c1, input int c2);
        step(0, 0, 0, 0, 0, 0, 0, 0, c1, c2);
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        iss_load = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        model_reset();
        #2;
        chk("rst_we0", 64'(we0), 64'd0);
        chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_waw", 64'(waw_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single ALU write, then idle.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_we", 64'(we0), 64'd1);
        chk("alu_addr", 64'(wr_addr0), 64'd5);
        chk("alu_din", 64'(wr_din0), 64'hDEADBEEF);
        idle(0, 0);
        chk("alu_we_drop", 64'(we0), 64'd0);

        // Load hazard on r7.
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        chk("ld_stall_set", 64'(stall), 64'd1);
        step(0, 0, 0, 1, 7, 32'h11, 0, 0, 7, 0);
        idle(7, 0);
        chk("ld_we", 64'(we0), 64'd1);
        chk("ld_addr", 64'(wr_addr0), 64'd7);
        chk("ld_din", 64'(wr_din0), 64'h11);
        chk("ld_stall_clr", 64'(stall), 64'd0);

        // ALU priority over two queued loads.
        step(1, 1, 32'hA1, 1, 3, 32'h33, 0, 0, 0, 0);
        step(1, 2, 32'hA2, 1, 4, 32'h44, 0, 0, 0, 0);
        step(1, 6, 32'hA6, 1, 8, 32'h88, 0, 0, 0, 0);
        chk("full_cnt", 64'(fifo_cnt), 64'd2);
        chk("full_ready", 64'(ld_ready), 64'd0);
        idle(0, 0);
        chk("drain_first", 64'(wr_addr0), 64'd3);
        idle(0, 0);
        chk("drain_second", 64'(wr_addr0), 64'd4);
        idle(0, 0);

        // Destination r0 writes are suppressed but consumed.
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_alu_we", 64'(we0), 64'd0);
        step(0, 0, 0, 1, 0, 32'h5, 0, 0, 0, 0);
        idle(0, 0);
        chk("r0_ld_we", 64'(we0), 64'd0);
        chk("r0_ld_cnt", 64'(fifo_cnt), 64'd0);

        // WAW on a pending register.
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
        chk("waw_set", 64'(waw_err), 64'd1);
        chk("waw_write", 64'(wr_addr0), 64'd9);
        idle(0, 0);
        chk("waw_sticky", 64'(waw_err), 64'd1);

        // Reset while the FIFO is full.
        step(1, 1, 32'h1, 1, 10, 32'hB0, 1, 3, 0, 0);
        step(1, 2, 32'h2, 1, 11, 32'hB1, 0, 0, 0, 0);
        chk("pre_rst_cnt", 64'(fifo_cnt), 64'd2);
        chk_rs1 = 3; chk_rs2 = 9;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("mid_rst_we0", 64'(we0), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_waw", 64'(waw_err), 64'd0);
        alu_valid = 0; ld_valid = 0; iss_load = 0;
        @(posedge clk); #1;
        chk("rst_hold_we0", 64'(we0), 64'd0);
        rst = 1'b1;
        idle(3, 9);
        chk("no_stale_we0", 64'(we0), 64'd0);
        idle(0, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 4, int'($urandom_range(0, 15)), $urandom(),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), $urandom(),
                 $urandom_range(0, 9) < 3, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
